matrix_deskew: RTL
==================

MATRIX_DESKEW -- requirements
Module: matrix_deskew

Interface
REQ-001 Parameter N, default 4: number of systolic output lanes (2..16).
REQ-002 Parameter W, default 16: data width per lane.
REQ-003 Parameter DEPTH, default 4: output FIFO entries (power of 2, >=2).
REQ-004 clk  in  1  clock; all state updates on the rising edge.
REQ-005 reset  in  1  reset, synchronous, active-high.
REQ-006 in_valid  in  N  per-lane valid; bit i belongs to lane i.
REQ-007 in_data  in  N*W  lane i occupies bits [i*W +: W].
REQ-008 out_valid  out  1  aligned row available at FIFO head.
REQ-009 out_ready  in  1  consumer accepts the row when out_valid is high.
REQ-010 out_data  out  N*W  aligned row, with the same lane packing as in_data.
REQ-011 overflow  out  1  sticky flag: a row was dropped because the FIFO was full.
REQ-012 align_err  out  1  sticky flag: a partial row was seen at alignment.
REQ-013 rows_out  out  16  count of rows handed off; wraps from 0xFFFF to 0.

Function
REQ-014 Input skew: lane i element of a row arrives i cycles after the lane 0 element, as produced by the skewed systolic array.
REQ-015 Delay line: lane i SHALL pass through a register chain of N-i stages, data and valid together; every lane has at least one register.
REQ-016 Alignment: delay-line outputs for one row appear in the same cycle.
  - Row-valid = AND of all N delayed valids.
REQ-017 Partial row: some, but not all, delayed valids high -> set align_err and discard that cycle's data; nothing written.
REQ-018 Write: row-valid and (not full, or a read in the same cycle) -> write the row to the FIFO.
REQ-019 Full: row-valid, FIFO full and no read that cycle -> row dropped and overflow set; FIFO contents unchanged.
REQ-020 Read: out_valid and out_ready in the same cycle -> pop head; rows_out increments by 1.
REQ-021 Simultaneous read and write: allowed at any occupancy, including full and empty; occupancy unchanged.
  - At empty, the written row does not bypass to the output in the same cycle.
REQ-022 FIFO behaviour: first-word fall-through.
  - out_valid = not empty.
  - out_data = head entry when out_valid is high, all zeros when out_valid is low.
REQ-023 Latency: row whose lane 0 element is presented in cycle c, with the FIFO empty -> on out_* in cycle c+N+1.
REQ-024 Throughput: one row per cycle sustained while out_ready is held high.
REQ-025 out_data and out_valid SHALL be held stable while out_valid is high and out_ready is low.
REQ-026 Pointers: wrap modulo DEPTH; occupancy counter is log2(DEPTH)+1 bits wide.
REQ-027 Flags: overflow and align_err clear only on reset.

Reset
REQ-028 reset high SHALL clear all delay-line valids, FIFO pointers, occupancy, overflow, align_err and rows_out.
REQ-029 Output values after reset: out_valid=0, out_data=0, overflow=0, align_err=0, rows_out=0, starting the cycle after the reset edge.
REQ-030 Reset asserted mid-operation SHALL discard rows in flight in the delay lines and FIFO; no partial row is emitted after reset.
REQ-031 Delay-line data and FIFO storage need not be reset.

Structure
REQ-032 Package matrix_pkg SHALL hold the default N, W and DEPTH constants shared with the skew-side delay blocks.
REQ-033 The FIFO SHALL be a sub-module deskew_fifo, parameterised by width N*W and DEPTH.
REQ-034 Delay lines SHALL be generated inline per lane.

Verification (N=4, W=16, DEPTH=4)
REQ-035 Skewed row, lane i = 0x1000+i presented in cycles 0..3, out_ready=1 -> out_valid in cycle 5 only, out_data=0x1003_1002_1001_1000, rows_out=1.
REQ-036 8 back-to-back skewed rows, out_ready=1 -> 8 consecutive valid rows in order, rows_out=8, overflow=0.
REQ-037 out_ready=0 with 5 rows pushed -> 4 rows held; overflow=1 after the 5th; then out_ready=1 -> rows 1..4 emitted and the 5th never appears.
REQ-038 Lane 2 valid omitted for one row -> align_err=1, nothing written, following full rows unaffected.
REQ-039 FIFO full, out_ready=1 and a new row arriving in the same cycle -> no overflow, occupancy stays 4.
REQ-040 reset asserted while 2 rows are in the delay lines and 2 in the FIFO -> next cycle all outputs 0; no stale row emitted afterwards.

Source files
------------

// File: rtl/matrix_pkg.sv
// Shared default geometry for the systolic output deskew path.
// The skew-side delay blocks and the deskew top use the same defaults,
// so lane count, lane width and FIFO depth all come from this package.
package matrix_pkg;

  localparam int N_DEFAULT     = 4;   // systolic output lanes
  localparam int W_DEFAULT     = 16;  // bits per lane
  localparam int DEPTH_DEFAULT = 4;   // aligned rows buffered at the output

endpackage : matrix_pkg

// File: rtl/deskew_fifo.sv
// First-word fall-through row FIFO for the deskew block.
// The head entry is visible combinationally while the FIFO is non-empty,
// and the output reads as zero when the FIFO is empty. A write made while
// the FIFO is empty becomes visible only from the next cycle. Reading and
// writing in the same cycle is allowed at every occupancy, including full.
module deskew_fifo
  import matrix_pkg::*;
#(
  parameter int WIDTH = N_DEFAULT * W_DEFAULT,
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             not_empty,
  output logic             full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             do_wr;
  logic             do_rd;

  assign full      = (count_reg == (AW+1)'(DEPTH));
  assign not_empty = (count_reg != '0);
  assign do_rd     = rd_en & not_empty;
  // A pop in the same cycle frees the slot that a full FIFO needs.
  assign do_wr     = wr_en & (~full | do_rd);
  assign rd_data   = not_empty ? mem[rd_ptr_reg] : '0;

  // Row storage: written at the tail, never reset.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  // Pointers and occupancy. The pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_wr) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_rd) rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule : deskew_fifo

// File: rtl/matrix_deskew.sv
// Realigns the skewed output rows of a systolic array. The lane i element
// of a row arrives i cycles after lane 0. Lane i is delayed by N-i
// registers, so every lane of a row reaches the alignment point in the
// same cycle. Complete rows are pushed into a small FWFT FIFO. Partial rows
// and rows dropped because the FIFO is full set sticky error flags.
module matrix_deskew
  import matrix_pkg::*;
#(
  parameter int N     = N_DEFAULT,
  parameter int W     = W_DEFAULT,
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   in_valid,
  input  logic [N*W-1:0] in_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N*W-1:0] out_data,
  output logic           overflow,
  output logic           align_err,
  output logic [15:0]    rows_out
);

  logic [N-1:0]   dly_valid;
  logic [N*W-1:0] dly_data;
  logic           row_valid;
  logic           row_partial;
  logic           fifo_full;
  logic           rd;
  logic           wr;
  logic           drop;
  logic           overflow_reg;
  logic           align_err_reg;
  logic [15:0]    rows_out_reg;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_lane
      localparam int STAGES = N - gi;
      logic [STAGES-1:0] v_reg;
      logic [W-1:0]      d_reg [STAGES];

      // Valid chain for this lane. Reset flushes any row that is in flight.
      always_ff @(posedge clk) begin
        if (reset) begin
          v_reg <= '0;
        end else begin
          v_reg[0] <= in_valid[gi];
          for (int k = 1; k < STAGES; k++) v_reg[k] <= v_reg[k-1];
        end
      end

      // Data chain, which moves in lockstep with the valid chain. It is not reset.
      always_ff @(posedge clk) begin
        d_reg[0] <= in_data[gi*W +: W];
        for (int k = 1; k < STAGES; k++) d_reg[k] <= d_reg[k-1];
      end

      assign dly_valid[gi]        = v_reg[STAGES-1];
      assign dly_data[gi*W +: W]  = d_reg[STAGES-1];
    end
  endgenerate

  assign row_valid   = &dly_valid;
  assign row_partial = (|dly_valid) & ~row_valid;
  assign rd          = out_valid & out_ready;
  assign wr          = row_valid & (~fifo_full | rd);
  assign drop        = row_valid & fifo_full & ~rd;

  deskew_fifo #(
    .WIDTH (N*W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (wr),
    .wr_data   (dly_data),
    .rd_en     (rd),
    .rd_data   (out_data),
    .not_empty (out_valid),
    .full      (fifo_full)
  );

  // Sticky error flags and the handoff counter. Only reset clears them.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_reg  <= 1'b0;
      align_err_reg <= 1'b0;
      rows_out_reg  <= '0;
    end else begin
      if (drop)        overflow_reg  <= 1'b1;
      if (row_partial) align_err_reg <= 1'b1;
      if (rd)          rows_out_reg  <= rows_out_reg + 1'b1;
    end
  end

  assign overflow  = overflow_reg;
  assign align_err = align_err_reg;
  assign rows_out  = rows_out_reg;

endmodule : matrix_deskew
